// File: rtl/multi_port_pmem_pkg.sv
// ============================================================================
// Module  : multi_port_pmem_pkg
// Brief   : Shared types and address-geometry helpers for the multi-port pmem.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_port_pmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_e;

    localparam int LINE_WIDTH_DFLT  = 256;
    localparam int DEPTH_LINES_DFLT = 1024;
    localparam int BYTES_PER_LINE   = LINE_WIDTH_DFLT / 8;
    localparam int OFS_BITS         = $clog2(BYTES_PER_LINE);
    localparam int IDX_BITS         = $clog2(DEPTH_LINES_DFLT);

    typedef logic [LINE_WIDTH_DFLT-1:0] line_t;

    function automatic int pmem_ofs_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    function automatic int pmem_idx_bits(input int depth_lines);
        return $clog2(depth_lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_port_pmem_rr_arbiter.sv
// ============================================================================
// Module  : pmem_rr_arbiter
// Brief   : Combinational round-robin arbiter; one-hot grant to the first
//           requester at or after the pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pmem_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_WIDTH = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_WIDTH-1:0] i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt
);

    logic                 w_found;
    logic [PTR_WIDTH-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = PTR_WIDTH'((int'(i_ptr) + i) % NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_port_pmem.sv
// ============================================================================
// Module  : multi_port_pmem
// Brief   : Multi-port cacheline memory model, round-robin arbitration, fixed
//           latency, per-port resp/sticky error.
// Config  : PMEM_WRITE_MASK_EN adds a per-byte write mask input (wmask).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_port_pmem
    import multi_port_pmem_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            read,
    input  logic [NUM_PORTS-1:0]            write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] wdata,
`ifdef PMEM_WRITE_MASK_EN
    input  logic [NUM_PORTS*(LINE_WIDTH/8)-1:0] wmask,
`endif
    output logic [NUM_PORTS-1:0]            resp,
    output logic [NUM_PORTS-1:0]            error,
    output logic [NUM_PORTS*LINE_WIDTH-1:0] rdata
);

    localparam int c_bytes    = LINE_WIDTH / 8;
    localparam int c_ofs_bits = pmem_ofs_bits(LINE_WIDTH);
    localparam int c_idx_bits = pmem_idx_bits(DEPTH_LINES);
    localparam int c_pw       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_cw       = $clog2(LATENCY + 1);

    pmem_state_e                 r_state, w_state_nxt;
    logic [c_pw-1:0]             r_ptr, r_gnt_id, w_sel_id, w_port;
    logic [NUM_PORTS-1:0]        w_req, w_gnt;
    logic [c_cw-1:0]             r_cnt;
    logic                        r_rd, r_wr, r_is_write, r_oor;
    logic [ADDR_WIDTH-1:0]       r_addr, w_cur_addr;
    logic [c_idx_bits-1:0]       r_idx;
    logic [LINE_WIDTH-1:0]       r_wdata, w_cur_wdata;
    logic                        w_cur_rd, w_cur_wr, w_cur_oor, w_proto_err;
    logic [NUM_PORTS-1:0]        r_resp, r_err;
    logic [NUM_PORTS*LINE_WIDTH-1:0] r_rdata;
    logic [LINE_WIDTH-1:0]       r_mem [DEPTH_LINES];
`ifdef PMEM_WRITE_MASK_EN
    logic [c_bytes-1:0]          r_wmask, w_cur_wmask;
`endif

    assign w_req = read | write;

    pmem_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_WIDTH (c_pw)
    ) u_arb (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_sel_id = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt[i]) w_sel_id = c_pw'(i);
        end
    end

    // In IDLE look at the port about to be granted, afterwards at the owner.
    assign w_port      = (r_state == IDLE) ? w_sel_id : r_gnt_id;
    assign w_cur_rd    = read[w_port];
    assign w_cur_wr    = write[w_port];
    assign w_cur_addr  = address[w_port*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_cur_wdata = wdata[w_port*LINE_WIDTH +: LINE_WIDTH];
    assign w_cur_oor   = (w_cur_addr >> (c_ofs_bits + c_idx_bits)) != '0;
`ifdef PMEM_WRITE_MASK_EN
    assign w_cur_wmask = wmask[w_port*c_bytes +: c_bytes];
    assign w_proto_err = (r_state == BUSY) &&
                         (({w_cur_rd, w_cur_wr} != {r_rd, r_wr}) ||
                          (w_cur_addr != r_addr) || (w_cur_wmask != r_wmask));
`else
    assign w_proto_err = (r_state == BUSY) &&
                         (({w_cur_rd, w_cur_wr} != {r_rd, r_wr}) ||
                          (w_cur_addr != r_addr));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (|w_req) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (r_cnt <= c_cw'(1)) w_state_nxt = RESP;
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt_id   <= '0;
            r_cnt      <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_is_write <= 1'b0;
            r_oor      <= 1'b0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
`ifdef PMEM_WRITE_MASK_EN
            r_wmask    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_resp  <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt_id   <= w_sel_id;
                        r_rd       <= w_cur_rd;
                        r_wr       <= w_cur_wr;
                        r_is_write <= w_cur_wr & ~w_cur_rd;
                        r_addr     <= w_cur_addr;
                        r_idx      <= w_cur_addr[c_ofs_bits +: c_idx_bits];
                        r_oor      <= w_cur_oor;
                        r_wdata    <= w_cur_wdata;
                        r_cnt      <= c_cw'(LATENCY - 1);
`ifdef PMEM_WRITE_MASK_EN
                        r_wmask    <= w_cur_wmask;
`endif
                        if ((w_cur_rd & w_cur_wr) | w_cur_oor) r_err[w_sel_id] <= 1'b1;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - c_cw'(1);
                    if (w_proto_err) r_err[r_gnt_id] <= 1'b1;
                end
                RESP: begin
                    r_resp[r_gnt_id] <= 1'b1;
                    if (!r_is_write)
                        r_rdata[r_gnt_id*LINE_WIDTH +: LINE_WIDTH] <= r_oor ? '0 : r_mem[r_idx];
                    r_ptr <= (r_gnt_id == c_pw'(NUM_PORTS - 1)) ? '0 : r_gnt_id + c_pw'(1);
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset; an async reset forces IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (r_state == RESP && r_is_write && !r_oor) begin
`ifdef PMEM_WRITE_MASK_EN
            for (int b = 0; b < c_bytes; b++) begin
                if (r_wmask[b]) r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
`else
            r_mem[r_idx] <= r_wdata;
`endif
        end
    end

    assign resp  = r_resp;
    assign error = r_err;
    assign rdata = r_rdata;

endmodule

`default_nettype wire
